updown_gray_counter: RTL
========================

UPDOWN_GRAY_COUNTER -- requirements
Module: updown_gray_counter

Interface
REQ-001 Parameter WIDTH, default 3, sets the counter width in bits; legal range 2..16.
REQ-002 Parameter SATURATE, default 0; 0 means the counter wraps at its limits, 1 means it holds at its limits.
REQ-003 Port clck  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port en  input  1  count enable.
REQ-006 Port A  input  1  direction: 1 counts up, 0 counts down.
REQ-007 Port ld  input  1  synchronous load strobe.
REQ-008 Port d  input  WIDTH  load value.
REQ-009 Port q  output  WIDTH  registered binary count.
REQ-010 Port g  output  WIDTH  registered Gray-coded count.
REQ-011 Port tc  output  1  terminal count, combinational.
REQ-012 Port wrap  output  1  registered one-cycle pulse that marks a wrap.

Function
REQ-013 Per rising edge, priority SHALL be: rst, then ld, then en, then hold.
REQ-014 On ld=1: q<=d, g<=d^(d>>1), and wrap<=0, regardless of en and A.
REQ-015 On en=1, A=1, ld=0: q<=q+1 modulo 2^WIDTH.
REQ-016 On en=1, A=0, ld=0: q<=q-1 modulo 2^WIDTH.
REQ-017 On en=0, ld=0: q and g hold, and wrap<=0.
REQ-018 g SHALL always equal q^(q>>1) and update on the same edge as q; there is no extra latency.
REQ-019 tc=1 iff en=1 and either (A=1 and q=all-ones) or (A=0 and q=0); otherwise tc=0.
REQ-020 SATURATE=0: when a count step occurs with tc=1, q wraps (all-ones to 0 up, 0 to all-ones down) and wrap<=1 for exactly one cycle.
REQ-021 SATURATE=1: when tc=1, q holds at the limit and wrap stays 0; tc stays high while the condition persists.
REQ-022 Direction change SHALL take effect on the next enabled edge; there is no dead cycle.
REQ-023 Any edge that is not a wrapping step SHALL clear wrap to 0.
REQ-024 Arithmetic SHALL be WIDTH bits unsigned; the carry/borrow out is used only to detect the wrap.

Reset
REQ-025 On a rising edge with rst=1: q=0, g=0, wrap=0; tc then follows REQ-019 from q=0.
REQ-026 rst asserted mid-count SHALL override ld and en on that edge; counting resumes from 0 on the first edge after rst falls.
REQ-027 Before the first reset edge, outputs are undefined; the bench SHALL assert rst at time 0.

Structure
REQ-028 The shared package holds the direction constants (UP=1, DOWN=0) and the mode constants (WRAP=0, SAT=1).
REQ-029 One sub-module, bin2gray (parameter WIDTH, purely combinational), computes the Gray code of the next-state value; it is instantiated once.
REQ-030 The block contains no latches, and uses a single always block for the q, g and wrap registers.

Verification (WIDTH=3 unless noted)
REQ-031 rst=1 for one edge, then en=1, A=1 -> q=0,g=000,wrap=0; q=1..7 over the next 7 edges; 8th edge q=0 with wrap=1 for one cycle; tc=1 while q=7.
REQ-032 From q=0 with en=1, A=0 -> next q=7, g=100, wrap=1; following edge q=6, g=101, wrap=0.
REQ-033 ld=1, d=5, en=1 on the same edge -> q=5, g=111, with no count applied; then ld=0, A=1 -> q=6, g=101.
REQ-034 SATURATE=1, count up from 5 -> q=6, 7, 7, 7; tc=1 from q=7 onward; wrap stays 0; then A=0 -> q=6.
REQ-035 Count up to q=4, then rst=1 with en=1, ld=1, d=3 -> q=0, g=0, wrap=0 on that edge.
REQ-036 WIDTH=4, SATURATE=0, up-count 16 edges from 0 -> every transition of g differs from the previous g in exactly one bit, and exactly one wrap pulse occurs.

Source files
------------

// File: rtl/updown_gray_counter_pkg.sv
// Shared constants for the up/down binary+Gray counter.
package updown_gray_counter_pkg;

  // Direction encoding on the A input.
  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  // Limit behaviour selected by the SATURATE parameter.
  localparam int WRAP = 0;
  localparam int SAT  = 1;

  // Smallest and largest supported counter widths.
  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 16;

endpackage : updown_gray_counter_pkg

// File: rtl/updown_gray_counter_bin2gray.sv
// Purely combinational binary-to-reflected-Gray converter.
module bin2gray #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  // Each Gray bit is the XOR of a binary bit and its next-higher neighbour;
  // the MSB passes straight through because the shifted-in bit is zero.
  assign gray = bin ^ (bin >> 1);

endmodule : bin2gray

// File: rtl/updown_gray_counter.sv
// Up/down counter with synchronous load, registered binary and Gray
// outputs, a combinational terminal-count flag and a one-cycle wrap pulse.
//
// Control semantics (no handshake): every rising clck edge is one step.
// Priority on an edge is rst, then ld, then en, then hold. tc is a pure
// function of the current q, en and A and says "the next enabled step in
// this direction crosses a limit". wrap is high for exactly the cycle that
// follows a step that crossed a limit in wrap mode; any other edge clears it.
module updown_gray_counter
  import updown_gray_counter_pkg::*;
#(
  parameter int WIDTH    = 3,
  parameter int SATURATE = WRAP
) (
  input  logic             clck,
  input  logic             rst,
  input  logic             en,
  input  logic             A,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] g,
  output logic             tc,
  output logic             wrap
);

  // Incrementer and decrementer results, carrying one extra bit so the
  // carry/borrow out can flag a limit crossing without a separate compare.
  logic [WIDTH:0]   inc_full;
  logic [WIDTH:0]   dec_full;
  logic             carry_out;
  logic             borrow_out;
  logic             limit_hit;

  // Next-state values for the registers.
  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] next_g;
  logic             next_wrap;

  // Arithmetic for both directions, WIDTH-bit unsigned with an extra MSB.
  always_comb begin
    inc_full   = {1'b0, q} + {{WIDTH{1'b0}}, 1'b1};
    dec_full   = {1'b0, q} - {{WIDTH{1'b0}}, 1'b1};
    carry_out  = inc_full[WIDTH];
    borrow_out = dec_full[WIDTH];
    limit_hit  = (A == UP) ? carry_out : borrow_out;
  end

  // Terminal count: only meaningful while counting is enabled.
  assign tc = en & limit_hit;

  // Next-state selection below reset: load beats count, count beats hold.
  always_comb begin
    next_q    = q;
    next_wrap = 1'b0;
    if (ld) begin
      next_q    = d;
      next_wrap = 1'b0;
    end else if (en) begin
      if (limit_hit && (SATURATE == SAT)) begin
        // Pinned at the limit; stay put and never signal a wrap.
        next_q    = q;
        next_wrap = 1'b0;
      end else begin
        next_q    = (A == UP) ? inc_full[WIDTH-1:0] : dec_full[WIDTH-1:0];
        next_wrap = limit_hit;
      end
    end
  end

  // Gray code of the value about to be registered, so g and q move together.
  bin2gray #(
    .WIDTH(WIDTH)
  ) u_bin2gray (
    .bin  (next_q),
    .gray (next_g)
  );

  // Single register block for q, g and wrap; reset has top priority.
  always_ff @(posedge clck) begin
    if (rst) begin
      q    <= '0;
      g    <= '0;
      wrap <= 1'b0;
    end else begin
      q    <= next_q;
      g    <= next_g;
      wrap <= next_wrap;
    end
  end

endmodule : updown_gray_counter
